// File: rtl/ntr_pkg.sv
// ntr_pkg: opcode constants and FSM state encoding shared by the command engine.
package ntr_pkg;

    localparam logic [7:0] OP_LED  = 8'hFF;   // LED write, responds with 1
    localparam logic [7:0] OP_FIFO = 8'h22;   // FIFO read with empty flag
    localparam logic [7:0] OP_ID   = 8'h90;   // chip ID
    localparam logic [7:0] OP_ONES = 8'h9F;   // all-ones word
    localparam logic [7:0] OP_STAT = 8'h3C;   // command statistics

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DECODE  = 2'd1,
        ST_RESPOND = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/ntr_word_build.sv
// ntr_word_build: combinational opcode-to-response-word mapping.
// Optional feature macro: NTR_CMD_STATS_EN (enables the statistics opcode word).
module ntr_word_build
    import ntr_pkg::*;
#(
    parameter int          WORD_W  = 32,
    parameter int          FIFO_W  = 8,
    parameter logic [31:0] CHIP_ID = 32'h807F01E0
) (
    input  logic [7:0]        opcode,
    input  logic [FIFO_W-1:0] fifo_data,
    input  logic              fifo_empty,
    input  logic [15:0]       stat_count,
    output logic [WORD_W-1:0] word
);

    localparam logic [WORD_W-1:0] ID_WORD = WORD_W'(CHIP_ID);

    // FIFO data is masked when empty so stale head bytes never leak out
    logic [FIFO_W-1:0] fifo_byte;
    logic [24:0]       empty_flag;

    assign fifo_byte  = fifo_empty ? '0 : fifo_data;
    assign empty_flag = {fifo_empty, 24'd0};

    // select the response word for the current opcode
    always_comb begin
        word = '0;
        case (opcode)
            OP_LED:  word = WORD_W'(1);
            OP_FIFO: word = WORD_W'(empty_flag) | WORD_W'(fifo_byte);
            OP_ID:   word = ID_WORD;
            OP_ONES: word = '1;
`ifdef NTR_CMD_STATS_EN
            OP_STAT: word = WORD_W'(stat_count);
`endif
            default: word = '0;
        endcase
    end

`ifndef NTR_CMD_STATS_EN
    logic unused_stat;
    assign unused_stat = &{1'b0, stat_count};
`endif

endmodule

// File: rtl/ntr_cmd_engine.sv
// ntr_cmd_engine: sequences decoded commands into bursts of response words,
// pops the FIFO for FIFO-read opcodes and drives the LED register.
// Optional feature macro: NTR_CMD_STATS_EN (saturating command counter).
module ntr_cmd_engine
    import ntr_pkg::*;
#(
    parameter int          WORD_W    = 32,
    parameter int          FIFO_W    = 8,
    parameter int          BURST_MAX = 4,
    parameter logic [31:0] CHIP_ID   = 32'h807F01E0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       cmd,
    input  logic              cmd_ready,
    input  logic              word_req,
    output logic [WORD_W-1:0] data_word,
    output logic              word_valid,
    input  logic [FIFO_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              led,
    output logic              busy,
    output logic [15:0]       cmd_count
);

    localparam logic [8:0] BURST_LIM = 9'(BURST_MAX);

    state_t            state_reg, state_next;
    logic [7:0]        opcode_reg;
    logic [8:0]        remaining_reg;
    logic [WORD_W-1:0] data_word_reg;
    logic              word_valid_reg;
    logic              led_reg;

    logic              load_first;
    logic              load_next;
    logic              go_idle;
    logic [7:0]        opcode_sel;
    logic [8:0]        len_req;
    logic [8:0]        rem_init;
    logic [15:0]       stat_sel;
    logic [WORD_W-1:0] word_built;

    // requested length is cmd[15:8]+1, clipped to the burst limit
    assign len_req  = {1'b0, cmd[15:8]} + 9'd1;
    assign rem_init = (len_req > BURST_LIM) ? BURST_LIM : len_req;

    // in DECODE the opcode is not latched yet, so take it straight from cmd
    assign opcode_sel = (state_reg == ST_DECODE) ? cmd[7:0] : opcode_reg;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // next-state logic; a dropped cmd_ready wins over any word request
    always_comb begin
        state_next = state_reg;
        load_first = 1'b0;
        load_next  = 1'b0;
        go_idle    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_ready) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (!cmd_ready) begin
                    state_next = ST_IDLE;
                    go_idle    = 1'b1;
                end else begin
                    state_next = ST_RESPOND;
                    load_first = 1'b1;
                end
            end
            ST_RESPOND: begin
                if (!cmd_ready) begin
                    state_next = ST_IDLE;
                    go_idle    = 1'b1;
                end else if (word_req) begin
                    if (remaining_reg > 9'd1) load_next  = 1'b1;
                    else                      state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!cmd_ready) begin
                    state_next = ST_IDLE;
                    go_idle    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // pop strobe coincides with the edge that captures a FIFO word
    assign fifo_rd_en = (load_first || load_next) && (opcode_sel == OP_FIFO) && !fifo_empty;

    // response word, burst length and LED registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_reg     <= '0;
            remaining_reg  <= '0;
            data_word_reg  <= '0;
            word_valid_reg <= 1'b0;
            led_reg        <= 1'b0;
        end else if (load_first) begin
            opcode_reg     <= cmd[7:0];
            remaining_reg  <= rem_init;
            data_word_reg  <= word_built;
            word_valid_reg <= 1'b1;
            if (cmd[7:0] == OP_LED) led_reg <= cmd[56];
        end else if (load_next) begin
            remaining_reg <= remaining_reg - 9'd1;
            data_word_reg <= word_built;
        end else if (go_idle) begin
            data_word_reg  <= '0;
            word_valid_reg <= 1'b0;
        end
    end

`ifdef NTR_CMD_STATS_EN
    logic [15:0] count_reg;
    logic [15:0] count_inc;

    assign count_inc = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;

    // count every command that reaches DECODE, saturating at all ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        count_reg <= '0;
        else if (state_reg == ST_DECODE)  count_reg <= count_inc;
    end

    // the statistics word includes the command being decoded
    assign stat_sel  = (state_reg == ST_DECODE) ? count_inc : count_reg;
    assign cmd_count = count_reg;
`else
    assign stat_sel  = '0;
    assign cmd_count = '0;
`endif

    ntr_word_build #(
        .WORD_W  (WORD_W),
        .FIFO_W  (FIFO_W),
        .CHIP_ID (CHIP_ID)
    ) u_word_build (
        .opcode     (opcode_sel),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .stat_count (stat_sel),
        .word       (word_built)
    );

    assign data_word  = data_word_reg;
    assign word_valid = word_valid_reg;
    assign led        = led_reg;
    assign busy       = (state_reg != ST_IDLE);

    logic unused_cmd;
    assign unused_cmd = &{1'b0, cmd[63:57], cmd[55:16]};

endmodule

// File: tb/tb_ntr_cmd_engine.sv
// tb_ntr_cmd_engine: directed self-checking bench for ntr_cmd_engine.
// Expected statistics word depends on NTR_CMD_STATS_EN.
module tb_ntr_cmd_engine;

    logic        clk;
    logic        reset;
    logic [63:0] cmd;
    logic        cmd_ready;
    logic        word_req;
    logic [31:0] data_word;
    logic        word_valid;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        led;
    logic        busy;
    logic [15:0] cmd_count;

    int n_cmp = 0;
    int n_err = 0;
    int pops  = 0;
    logic [7:0] fq[$];

`ifdef NTR_CMD_STATS_EN
    localparam logic [31:0] EXP_STAT = 32'd4;
`else
    localparam logic [31:0] EXP_STAT = 32'd0;
`endif

    ntr_cmd_engine dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd),
        .cmd_ready  (cmd_ready),
        .word_req   (word_req),
        .data_word  (data_word),
        .word_valid (word_valid),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .led        (led),
        .busy       (busy),
        .cmd_count  (cmd_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // present the head of the bench FIFO; garbage on the data bus when empty
    task automatic fifo_drive();
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() == 0) ? 8'h5A : fq[0];
    endtask

    // one clock: sample the pop strobe before the edge, return at edge+1
    task automatic tick();
        logic rd;
        #3;
        rd = fifo_rd_en;
        if (rd) pops++;
        @(posedge clk);
        #1;
        if (rd && fq.size() > 0) void'(fq.pop_front());
        fifo_drive();
    endtask

    task automatic start_cmd(input logic [63:0] c);
        cmd       = c;
        cmd_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic end_cmd();
        cmd_ready = 1'b0;
        tick();
    endtask

    task automatic req();
        word_req = 1'b1;
        tick();
        word_req = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cmd       = '0;
        cmd_ready = 1'b0;
        word_req  = 1'b0;
        fq.delete();
        fifo_drive();
        @(posedge clk);
        #1;
        tick();
        check("rst_data_word", data_word, 0);
        check("rst_word_valid", word_valid, 0);
        check("rst_fifo_rd_en", fifo_rd_en, 0);
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_count", cmd_count, 0);
        reset = 1'b0;
        tick();

        // LED command: word 1 two cycles after cmd_ready, held until cmd_ready falls
        cmd       = 64'h0100_0000_0000_00FF;
        cmd_ready = 1'b1;
        tick();
        check("led_decode_busy", busy, 1);
        check("led_decode_valid", word_valid, 0);
        tick();
        check("led_led", led, 1);
        check("led_word", data_word, 1);
        check("led_valid", word_valid, 1);
        req();
        tick();
        check("led_hold_valid", word_valid, 1);
        check("led_hold_busy", busy, 1);
        end_cmd();
        check("led_idle_valid", word_valid, 0);
        check("led_idle_busy", busy, 0);
        req();
        check("led_stray_req_busy", busy, 0);

        // FIFO read, length 3, FIFO holds A1,B2
        fq = '{8'hA1, 8'hB2};
        fifo_drive();
        pops = 0;
        start_cmd(64'h0000_0000_0000_0222);
        check("fifo_w0", data_word, 32'h0000_00A1);
        req();
        check("fifo_w1", data_word, 32'h0000_00B2);
        req();
        check("fifo_w2_empty", data_word, 32'h0100_0000);
        req();
        check("fifo_hold_word", data_word, 32'h0100_0000);
        check("fifo_pops", pops, 2);
        end_cmd();

        // chip ID, length clipped to 4 words, extra request ignored
        start_cmd(64'h0000_0000_0000_0990);
        check("id_w0", data_word, 32'h807F_01E0);
        for (int i = 1; i <= 5; i++) begin
            req();
            check($sformatf("id_req%0d", i), data_word, 32'h807F_01E0);
        end
        check("id_valid", word_valid, 1);
        check("id_busy", busy, 1);
        end_cmd();

        // FIFO read with length 10 clipped to 4: only 4 pops despite 6 bytes
        fq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        fifo_drive();
        pops = 0;
        start_cmd(64'h0000_0000_0000_0922);
        check("clip_w0", data_word, 32'h01);
        for (int i = 1; i <= 5; i++) req();
        check("clip_last", data_word, 32'h04);
        check("clip_pops", pops, 4);
        end_cmd();
        fq.delete();
        fifo_drive();

        // abort in RESPOND with a simultaneous word request
        fq = '{8'hC3, 8'hD4};
        fifo_drive();
        pops = 0;
        start_cmd(64'h0000_0000_0000_0522);
        check("abort_w0", data_word, 32'hC3);
        cmd_ready = 1'b0;
        word_req  = 1'b1;
        tick();
        word_req = 1'b0;
        check("abort_pops", pops, 1);
        check("abort_valid", word_valid, 0);
        check("abort_busy", busy, 0);

        // abort in DECODE: no pop, no word
        cmd       = 64'h0000_0000_0000_0022;
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        tick();
        check("dec_abort_pops", pops, 1);
        check("dec_abort_valid", word_valid, 0);
        check("dec_abort_busy", busy, 0);
        fq.delete();
        fifo_drive();

        // reset mid-burst
        fq = '{8'h11, 8'h22, 8'h33};
        fifo_drive();
        pops = 0;
        start_cmd(64'h0000_0000_0000_0222);
        check("mid_w0", data_word, 32'h11);
        word_req = 1'b1;
        reset    = 1'b1;
        #1;
        check("mid_rst_data", data_word, 0);
        check("mid_rst_valid", word_valid, 0);
        check("mid_rst_rd_en", fifo_rd_en, 0);
        check("mid_rst_led", led, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", cmd_count, 0);
        #2;
        tick();
        tick();
        check("mid_rst_pops", pops, 1);
        word_req  = 1'b0;
        cmd_ready = 1'b0;
        reset     = 1'b0;
        tick();
        start_cmd(64'h0000_0000_0000_0090);
        check("post_rst_id", data_word, 32'h807F_01E0);
        end_cmd();

        // more opcodes, then statistics word after 3 completed commands
        start_cmd(64'h0000_0000_0000_009F);
        check("ones_word", data_word, 32'hFFFF_FFFF);
        end_cmd();
        start_cmd(64'h0000_0000_0000_0055);
        check("other_word", data_word, 32'h0);
        end_cmd();
        start_cmd(64'h0000_0000_0000_003C);
        check("stat_word", data_word, EXP_STAT);
        check("stat_count", cmd_count, EXP_STAT);
        end_cmd();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
